scan_decoder: RTL and testbench
===============================

// Module: scan_decoder
// PURPOSE
//   Registered, parametrised SEL_W-to-2^SEL_W one-hot decoder with two modes.
//   DIRECT: decodes a handshaked select value.
//   SCAN: auto-walks the one-hot output with a programmable dwell, e.g. for
//   multiplexed 7-segment anode drive.
//   Sits between control logic and display/chip-select fan-out, replacing
//   fixed 3-to-8 gate-level decoders.
// PARAMETERS
//   SEL_W       3   select width; OUT_W = 2**SEL_W outputs (localparam)
//   DWELL       4   cycles each output stays active in SCAN; legal range >= 1
//   ACTIVE_LOW  0   1: active output bit is 0, inactive bits are 1
// PORTS
//   clk       in   1      rising-edge clock, sole clock
//   rst       in   1      synchronous, active-high reset
//   en        in   1      block enable; 0 forces outputs inactive
//   mode      in   1      0 = DIRECT, 1 = SCAN
//   in_valid  in   1      DIRECT: sel is valid
//   in_ready  out  1      DIRECT: sel accepted when in_valid & in_ready
//   sel       in   SEL_W  select value, DIRECT mode only
//   dec_out   out  OUT_W  registered one-hot (or one-cold) output
//   cur_idx   out  SEL_W  index of the currently active output bit
//   wrap      out  1      1-cycle pulse when SCAN index wraps OUT_W-1 -> 0
// BEHAVIOUR
//   Reset (rst=1 at clk edge, any state):
//     state=IDLE, dec_out=INACT (all 0, or all 1 if ACTIVE_LOW),
//     cur_idx=0, wrap=0, in_ready=1, dwell_cnt=0.
//   All outputs are registered. Priority: rst > en=0 > mode.
//   States:
//     IDLE: dec_out=INACT.
//       en&~mode -> DIRECT.  en&mode -> SCAN.
//     DIRECT:
//       in_ready=1.
//       Accept (in_valid&in_ready) -> next cycle dec_out=onehot(sel),
//       cur_idx=sel. Latency is 1 cycle.
//       No accept -> dec_out and cur_idx hold.
//       mode=1 -> SCAN.
//     SCAN:
//       in_ready=0; in_valid and sel are ignored.
//       Entry (from IDLE or DIRECT): next cycle cur_idx=0, dec_out=onehot(0),
//       dwell_cnt=0, wrap=0.
//       Each cycle dwell_cnt++. When dwell_cnt==DWELL-1: dwell_cnt=0 and
//       cur_idx advances by 1 (mod OUT_W).
//       The advance OUT_W-1 -> 0 sets wrap=1 for exactly that cycle.
//       SCAN entry never asserts wrap.
//       DWELL=1: advance every cycle; wrap every OUT_W cycles.
//       mode=0 -> DIRECT; dec_out and cur_idx hold at the current index
//       until the next accept; dwell_cnt=0.
//     Any state with en=0 -> IDLE next cycle:
//       dec_out=INACT, wrap=0, cur_idx holds, in_ready=1.
//   Simultaneous events:
//     - Accept and mode 0->1 in the same cycle: the mode change wins and the
//       sel value is dropped. in_ready was already 1, so the bench must not
//       expect that sel to appear.
//     - en falling in the same cycle as a wrap advance: IDLE wins, wrap=0.
//   Invariant: dec_out has exactly one active bit whenever the state is
//   DIRECT after its first accept, or SCAN. Otherwise it is INACT.
// TESTING
//   1. rst=1 two cycles -> dec_out=8'h00, cur_idx=0, wrap=0, in_ready=1.
//   2. DIRECT, en=1, accept sel=5 -> next cycle dec_out=8'h20, cur_idx=5.
//      Idle 3 cycles -> holds 8'h20.
//   3. SCAN, DWELL=4 -> dec_out 8'h01 for 4 cycles, then 8'h02, ..., 8'h80.
//      Then 8'h01 with wrap=1 for one cycle; one full period is 32 cycles.
//   4. ACTIVE_LOW=1, SEL_W=2, DIRECT sel=2 -> dec_out=4'b1011.
//      en=0 -> next cycle dec_out=4'b1111.
//   5. Mid-SCAN at idx 3, rst=1 for one cycle -> next cycle all reset values.
//      With rst released, en=1, mode=1 -> scan restarts at idx 0 with no wrap.
//   6. Mid-SCAN at idx 6, mode->0 -> holds 8'h40, in_ready=1.
//      Accept sel=1 -> 8'h02. Also cover DWELL=1 wrap every 8 cycles.

Source files
------------

// File: rtl/scan_decoder.sv
// -----------------------------------------------------------------------------
// scan_decoder
//   Registered SEL_W-to-2**SEL_W one-hot (or one-cold) decoder with two modes:
//     DIRECT - decodes a select value taken through a valid/ready handshake.
//     SCAN   - walks the active output bit across all outputs, holding each
//              one for DWELL cycles (e.g. multiplexed 7-segment anode drive).
//   All outputs are registered. Priority: rst > en=0 > mode.
//
// Parameters
//   SEL_W       select width; there are 2**SEL_W outputs
//   DWELL       cycles each output stays active in SCAN (>= 1)
//   ACTIVE_LOW  1: the active bit is 0 and inactive bits are 1
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset
//   en        in   block enable; 0 forces outputs inactive (state IDLE)
//   mode      in   0 = DIRECT, 1 = SCAN
//   in_valid  in   DIRECT: sel is valid
//   in_ready  out  sel accepted when in_valid & in_ready (0 while scanning)
//   sel       in   select value, DIRECT mode only
//   dec_out   out  registered one-hot / one-cold output
//   cur_idx   out  index of the currently selected output bit
//   wrap      out  one-cycle pulse when the scan index wraps to 0
// -----------------------------------------------------------------------------
module scan_decoder #(
  parameter int SEL_W      = 3,
  parameter int DWELL      = 4,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  mode,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SEL_W-1:0]      sel,
  output logic [2**SEL_W-1:0]   dec_out,
  output logic [SEL_W-1:0]      cur_idx,
  output logic                  wrap
);

  localparam int OUT_W = 2**SEL_W;
  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] IDX_LAST   = {SEL_W{1'b1}};
  localparam logic [OUT_W-1:0] INACT      = ACTIVE_LOW ? {OUT_W{1'b1}} : {OUT_W{1'b0}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DIRECT = 2'd1,
    S_SCAN   = 2'd2
  } state_e;

  // One-hot pattern for an index, inverted for one-cold outputs.
  function automatic logic [OUT_W-1:0] decode(input logic [SEL_W-1:0] idx);
    logic [OUT_W-1:0] hot;
    hot = {{(OUT_W-1){1'b0}}, 1'b1} << idx;
    return ACTIVE_LOW ? ~hot : hot;
  endfunction

  state_e             state_q, state_d;
  logic [OUT_W-1:0]   dec_q,   dec_d;
  logic [SEL_W-1:0]   idx_q,   idx_d;
  logic               wrap_q,  wrap_d;
  logic               ready_q, ready_d;
  logic [CNT_W-1:0]   dwell_q, dwell_d;

  logic               accept_s;
  logic [SEL_W-1:0]   idx_inc_s;

  // A handshake only counts while the block stays in (or enters) DIRECT; a
  // simultaneous switch to SCAN drops the offered sel.
  assign accept_s  = in_valid & ready_q & en & ~mode;
  assign idx_inc_s = idx_q + SEL_W'(1);

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      dec_q   <= INACT;
      idx_q   <= {SEL_W{1'b0}};
      wrap_q  <= 1'b0;
      ready_q <= 1'b1;
      dwell_q <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      dec_q   <= dec_d;
      idx_q   <= idx_d;
      wrap_q  <= wrap_d;
      ready_q <= ready_d;
      dwell_q <= dwell_d;
    end
  end

  // Next state: en has priority, then mode picks the operating state.
  always_comb begin
    if (!en) begin
      state_d = S_IDLE;
    end else if (mode) begin
      state_d = S_SCAN;
    end else begin
      state_d = S_DIRECT;
    end
  end

  // Next registered outputs, derived from the state being entered.
  always_comb begin
    dec_d   = dec_q;
    idx_d   = idx_q;
    wrap_d  = 1'b0;
    ready_d = 1'b1;
    dwell_d = {CNT_W{1'b0}};
    case (state_d)
      S_IDLE: begin
        // cur_idx deliberately holds while idle.
        dec_d = INACT;
      end
      S_DIRECT: begin
        // Coming from SCAN the current index simply holds until an accept.
        if (accept_s) begin
          idx_d = sel;
          dec_d = decode(sel);
        end else begin
          dec_d = dec_q;
        end
      end
      S_SCAN: begin
        ready_d = 1'b0;
        if (state_q != S_SCAN) begin
          // Scan entry restarts at index 0 and never flags a wrap.
          idx_d = {SEL_W{1'b0}};
          dec_d = decode({SEL_W{1'b0}});
        end else if (dwell_q == DWELL_LAST) begin
          idx_d  = idx_inc_s;
          dec_d  = decode(idx_inc_s);
          wrap_d = (idx_q == IDX_LAST);
        end else begin
          dwell_d = dwell_q + CNT_W'(1);
        end
      end
      default: begin
        dec_d = INACT;
      end
    endcase
  end

  assign dec_out  = dec_q;
  assign cur_idx  = idx_q;
  assign wrap     = wrap_q;
  assign in_ready = ready_q;

endmodule

// File: tb/tb_scan_decoder.sv
// -----------------------------------------------------------------------------
// tb_scan_decoder
//   Three scan_decoder configurations share one stimulus stream:
//     u0: SEL_W=3 DWELL=4 active-high
//     u1: SEL_W=2 DWELL=3 active-low
//     u2: SEL_W=3 DWELL=1 active-high
//   A behavioural model tracks, per configuration, whether it is scanning,
//   the time since scan entry (the index is derived as (t/DWELL) % outputs),
//   the last selected index and whether an output is shown. One process
//   checks every output each cycle; directed literal checks pin the model.
// -----------------------------------------------------------------------------
module tb_scan_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, mode, in_valid;
  logic [2:0] sel;

  logic [7:0] dec0, dec2;
  logic [3:0] dec1;
  logic [2:0] idx0, idx2;
  logic [1:0] idx1;
  logic       rdy0, rdy1, rdy2, wr0, wr1, wr2;

  scan_decoder #(.SEL_W(3), .DWELL(4), .ACTIVE_LOW(1'b0)) u0 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .in_valid(in_valid),
    .in_ready(rdy0), .sel(sel), .dec_out(dec0), .cur_idx(idx0), .wrap(wr0));

  scan_decoder #(.SEL_W(2), .DWELL(3), .ACTIVE_LOW(1'b1)) u1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .in_valid(in_valid),
    .in_ready(rdy1), .sel(sel[1:0]), .dec_out(dec1), .cur_idx(idx1), .wrap(wr1));

  scan_decoder #(.SEL_W(3), .DWELL(1), .ACTIVE_LOW(1'b0)) u2 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .in_valid(in_valid),
    .in_ready(rdy2), .sel(sel), .dec_out(dec2), .cur_idx(idx2), .wrap(wr2));

  localparam int CFG_SW [3] = '{3, 2, 3};
  localparam int CFG_DW [3] = '{4, 3, 1};
  localparam int CFG_AL [3] = '{0, 1, 0};

  int n_chk  = 0;
  int n_fail = 0;

  // Behavioural model state per configuration.
  bit m_scan  [3] = '{0, 0, 0};
  bit m_shown [3] = '{0, 0, 0};
  bit m_wrap  [3] = '{0, 0, 0};
  int m_t     [3] = '{0, 0, 0};
  int m_idx   [3] = '{0, 0, 0};

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_step(input int i, input bit r, input bit e,
                                     input bit md, input bit v, input int s);
    int n;
    n = 1 << CFG_SW[i];
    if (r) begin
      m_scan[i] = 0; m_shown[i] = 0; m_wrap[i] = 0; m_t[i] = 0; m_idx[i] = 0;
    end else if (!e) begin
      m_scan[i] = 0; m_shown[i] = 0; m_wrap[i] = 0;
    end else if (md) begin
      if (m_scan[i]) begin
        m_t[i]++;
        m_idx[i]  = (m_t[i] / CFG_DW[i]) % n;
        m_wrap[i] = (m_t[i] % (CFG_DW[i] * n)) == 0;
      end else begin
        m_scan[i] = 1; m_t[i] = 0; m_idx[i] = 0; m_shown[i] = 1; m_wrap[i] = 0;
      end
    end else begin
      m_wrap[i] = 0;
      if (m_scan[i]) begin
        m_scan[i] = 0;            // index and output hold
      end else if (v) begin
        m_idx[i]   = s % n;
        m_shown[i] = 1;
      end
    end
  endfunction

  function automatic int exp_dec(input int i);
    int n, v;
    n = 1 << CFG_SW[i];
    v = m_shown[i] ? (1 << m_idx[i]) : 0;
    if (CFG_AL[i] != 0) v = (~v) & ((1 << n) - 1);
    return v;
  endfunction

  // Compare process: step the model on each edge, check all outputs just after.
  bit c_r, c_e, c_m, c_v;
  int c_s;
  initial begin
    forever begin
      @(posedge clk);
      c_r = rst; c_e = en; c_m = mode; c_v = in_valid; c_s = int'(sel);
      for (int i = 0; i < 3; i++) model_step(i, c_r, c_e, c_m, c_v, c_s);
      #1;
      chk("u0.dec_out",  int'(dec0), exp_dec(0));
      chk("u0.cur_idx",  int'(idx0), m_idx[0]);
      chk("u0.wrap",     int'(wr0),  int'(m_wrap[0]));
      chk("u0.in_ready", int'(rdy0), int'(!m_scan[0]));
      chk("u1.dec_out",  int'(dec1), exp_dec(1));
      chk("u1.cur_idx",  int'(idx1), m_idx[1]);
      chk("u1.wrap",     int'(wr1),  int'(m_wrap[1]));
      chk("u1.in_ready", int'(rdy1), int'(!m_scan[1]));
      chk("u2.dec_out",  int'(dec2), exp_dec(2));
      chk("u2.cur_idx",  int'(idx2), m_idx[2]);
      chk("u2.wrap",     int'(wr2),  int'(m_wrap[2]));
      chk("u2.in_ready", int'(rdy2), int'(!m_scan[2]));
    end
  end

  // Directed sequence with literal expectations, then randomized traffic.
  initial begin
    rst = 1'b1; en = 1'b0; mode = 1'b0; in_valid = 1'b0; sel = 3'd0;
    repeat (2) @(negedge clk);
    chk("rst_dec0",   int'(dec0), 8'h00);
    chk("rst_dec1",   int'(dec1), 4'hF);
    chk("rst_idx0",   int'(idx0), 0);
    chk("rst_wrap0",  int'(wr0),  0);
    chk("rst_ready0", int'(rdy0), 1);

    // DIRECT decode and hold
    rst = 1'b0; en = 1'b1;
    @(negedge clk);
    chk("direct_noaccept", int'(dec0), 8'h00);
    in_valid = 1'b1; sel = 3'd5;
    @(negedge clk);
    chk("direct_sel5_dec", int'(dec0), 8'h20);
    chk("direct_sel5_idx", int'(idx0), 5);
    chk("direct_sel1_al",  int'(dec1), 4'b1101);
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("direct_hold", int'(dec0), 8'h20);
    end

    // one-cold decode, then en=0
    in_valid = 1'b1; sel = 3'd2;
    @(negedge clk);
    chk("al_sel2", int'(dec1), 4'b1011);
    chk("hi_sel2", int'(dec0), 8'h04);
    in_valid = 1'b0; en = 1'b0;
    @(negedge clk);
    chk("al_en0",      int'(dec1), 4'b1111);
    chk("en0_dec0",    int'(dec0), 8'h00);
    chk("en0_idxhold", int'(idx0), 2);

    // SCAN with DWELL=4 (u0) and DWELL=1 (u2)
    en = 1'b1; mode = 1'b1;
    for (int k = 0; k < 34; k++) begin
      @(negedge clk);
      chk("scan_dec0",  int'(dec0), (k < 32) ? (1 << (k / 4)) : 1);
      chk("scan_wrap0", int'(wr0),  (k == 32) ? 1 : 0);
      chk("scan_wrap2", int'(wr2),  (k > 0 && k % 8 == 0) ? 1 : 0);
      if (k == 0) chk("scan_ready0", int'(rdy0), 0);
    end
    repeat (24) @(negedge clk);     // scan time 57 -> index 6
    chk("scan_idx6", int'(dec0), 8'h40);
    mode = 1'b0;
    @(negedge clk);
    chk("s2d_hold_dec", int'(dec0), 8'h40);
    chk("s2d_hold_idx", int'(idx0), 6);
    chk("s2d_ready",    int'(rdy0), 1);
    in_valid = 1'b1; sel = 3'd1;
    @(negedge clk);
    chk("s2d_sel1", int'(dec0), 8'h02);
    in_valid = 1'b0;

    // reset mid-scan, then restart
    mode = 1'b1;
    @(negedge clk);
    repeat (13) @(negedge clk);
    chk("scan_idx3", int'(idx0), 3);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_dec0", int'(dec0), 8'h00);
    chk("midrst_idx0", int'(idx0), 0);
    chk("midrst_rdy0", int'(rdy0), 1);
    chk("midrst_dec1", int'(dec1), 4'hF);
    rst = 1'b0;
    @(negedge clk);
    chk("restart_dec0",  int'(dec0), 8'h01);
    chk("restart_idx0",  int'(idx0), 0);
    chk("restart_wrap0", int'(wr0),  0);

    // en falls on the wrap edge: IDLE wins, no wrap
    repeat (31) @(negedge clk);
    chk("prewrap_dec0", int'(dec0), 8'h80);
    en = 1'b0;
    @(negedge clk);
    chk("enwrap_dec0",  int'(dec0), 8'h00);
    chk("enwrap_wrap0", int'(wr0),  0);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst      = ($urandom_range(0, 63) == 0);
      en       = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      in_valid = $urandom_range(0, 1) != 0;
      sel      = 3'($urandom_range(0, 7));
      @(negedge clk);
    end
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
